// File: rtl/speed_test_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : speed_test_frame_checker
// Description : Per-port receive checker. Classifies each returned AXI-Stream
//               frame as good or bad against the captured port configuration
//               and keeps saturating good/bad frame and good byte counters.
// Revision    : 1.0 - initial release
// ============================================================================
module speed_test_frame_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    start,
    input  logic                    stop,
    input  logic [191:0]            port_config,
    output logic                    check_ready,
    output logic [127:0]            check_results
);

    localparam int CNT_W   = $clog2(KEEP_WIDTH + 1);
    localparam int MIN_LEN = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic           check_ready_q;
    logic [47:0]    cfg_dst_q;
    logic [15:0]    cfg_type_q;

    // Frame tracking state
    logic           in_frame_q;
    logic [1:0]     beats_q;        // beats seen so far, saturates at 2
    logic [15:0]    len_q;
    logic           mac_ok_q;
    logic           type_ok_q;
    logic           counted_q;      // frame began inside a run and is not foreign

    // One-cycle delayed counter update
    logic           pend_q;
    logic           pend_good_q;
    logic [15:0]    pend_len_q;

    logic [31:0]    good_frames_q;
    logic [31:0]    bad_frames_q;
    logic [63:0]    good_bytes_q;

    logic [CNT_W-1:0] beat_bytes;
    logic             first_beat;
    logic [1:0]       beat_idx;
    logic [1:0]       beats_d;
    logic [16:0]      len_sum;
    logic [15:0]      len_d;
    logic             mac_ok_d;
    logic             type_ok_d;
    logic             counted_d;
    logic             frame_done;
    logic             frame_good;
    logic [31:0]      good_frames_d;
    logic [31:0]      bad_frames_d;
    logic [63:0]      good_bytes_d;
    logic [64:0]      bytes_sum;
    logic             unused_ok;

    assign s_axis_tready = 1'b1;
    assign check_ready   = check_ready_q;
    assign check_results = {good_bytes_q, bad_frames_q, good_frames_q};
    assign unused_ok     = ^{port_config[191:64], s_axis_tdata[DATA_WIDTH-1:48]};

    // Run control: start wins over stop; config captured only on start
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            check_ready_q <= 1'b1;
            cfg_dst_q     <= '0;
            cfg_type_q    <= '0;
        end else if (start) begin
            state_q       <= ST_RUN;
            check_ready_q <= 1'b0;
            cfg_dst_q     <= port_config[47:0];
            cfg_type_q    <= port_config[63:48];
        end else if (stop && (state_q == ST_RUN)) begin
            state_q       <= ST_DONE;
            check_ready_q <= 1'b1;
        end
    end

    // Per-beat classification; the verdict is formed on the tlast beat
    always_comb begin
        beat_bytes = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            beat_bytes = beat_bytes + {{(CNT_W-1){1'b0}}, s_axis_tkeep[k]};
        end
        first_beat = !in_frame_q;
        beat_idx   = first_beat ? 2'd0 : beats_q;
        beats_d    = (beat_idx == 2'd2) ? 2'd2 : beat_idx + 2'd1;
        len_sum    = {1'b0, (first_beat ? 16'd0 : len_q)}
                   + {{(17-CNT_W){1'b0}}, beat_bytes};
        len_d      = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        mac_ok_d   = first_beat ? (s_axis_tdata[47:0] == cfg_dst_q) : mac_ok_q;
        if (first_beat) begin
            type_ok_d = 1'b0;
        end else if (beat_idx == 2'd1) begin
            type_ok_d = ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == cfg_type_q);
        end else begin
            type_ok_d = type_ok_q;
        end
        // A start pulse turns any frame in progress (or starting now) foreign
        counted_d  = first_beat ? ((state_q == ST_RUN) && !start) : (counted_q && !start);
        frame_done = s_axis_tvalid && s_axis_tlast && counted_d && (state_q == ST_RUN);
        frame_good = mac_ok_d && type_ok_d && !first_beat
                   && (len_d >= 16'(MIN_LEN)) && !s_axis_tuser;
    end

    // Frame tracking runs in every state so frame boundaries are never lost
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_frame_q  <= 1'b0;
            beats_q     <= '0;
            len_q       <= '0;
            mac_ok_q    <= 1'b0;
            type_ok_q   <= 1'b0;
            counted_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_good_q <= 1'b0;
            pend_len_q  <= '0;
        end else begin
            pend_q      <= frame_done;
            pend_good_q <= frame_good;
            pend_len_q  <= len_d;
            if (s_axis_tvalid) begin
                in_frame_q <= !s_axis_tlast;
                beats_q    <= beats_d;
                len_q      <= len_d;
                mac_ok_q   <= mac_ok_d;
                type_ok_q  <= type_ok_d;
                counted_q  <= counted_d;
            end else begin
                counted_q  <= counted_q && !start;
            end
        end
    end

    // Saturating next values for the result counters
    always_comb begin
        good_frames_d = good_frames_q;
        bad_frames_d  = bad_frames_q;
        good_bytes_d  = good_bytes_q;
        bytes_sum     = {1'b0, good_bytes_q} + {49'd0, pend_len_q};
        if (pend_q) begin
            if (pend_good_q) begin
                if (good_frames_q != 32'hFFFF_FFFF) begin
                    good_frames_d = good_frames_q + 32'd1;
                end
                good_bytes_d = bytes_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : bytes_sum[63:0];
            end else if (bad_frames_q != 32'hFFFF_FFFF) begin
                bad_frames_d = bad_frames_q + 32'd1;
            end
        end
    end

    // Result counters: cleared on start, otherwise take the pending update
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            good_frames_q <= '0;
            bad_frames_q  <= '0;
            good_bytes_q  <= '0;
        end else begin
            good_frames_q <= good_frames_d;
            bad_frames_q  <= bad_frames_d;
            good_bytes_q  <= good_bytes_d;
        end
    end

endmodule
`default_nettype wire
